issue_queue_ctrl: RTL and testbench

//  Instruction issue sequencer between fetch and the decoder. Buffers fetched
//  (inst, pc) pairs in a circular FIFO and presents the head to the decoder.

---
 rtl/issue_queue_ctrl.sv | 150 +++++++++++++++
 tb/tb_issue_queue_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/issue_queue_ctrl.sv
// rtl/issue_queue_ctrl.sv - fetch-to-decoder issue FIFO with load/store classification
//
// Buffers fetched (inst, pc) pairs in a circular FIFO and presents the head
// slot to the decoder. The head is popped once the decoder reports that the
// ROB and the target station can accept it. A ROB clear (mispredict) empties
// the queue.
//
// Ports
//   clk_in           in   1            clock, rising edge
//   rst_in           in   1            asynchronous reset, active-low
//   rdy_in           in   1            global ready; 0 freezes all state
//   rob_clear        in   1            synchronous flush request
//   fetch_valid      in   1            fetch offers an instruction
//   fetch_inst       in   32           fetched instruction word
//   fetch_pc         in   32           pc of fetch_inst
//   queue_full       out  1            count == DEPTH; fetch must hold
//   inst_to_dec      out  32           head instruction, 0 when empty
//   pc_to_dec        out  32           head pc, `emptyInst when empty
//   if_ls            out  1            head is a load or store
//   if_station_idle  in   1            decoder can accept the head
//   count            out  ADDR_BITS+1  number of valid entries
//   issued_cnt       out  32           instructions issued since reset

`ifndef emptyInst
`define emptyInst 32'hFFFF_FFFF
`endif

module issue_queue_ctrl #(
    parameter int DEPTH     = 16,
    parameter int ADDR_BITS = 4
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 rob_clear,
    input  logic                 fetch_valid,
    input  logic [31:0]          fetch_inst,
    input  logic [31:0]          fetch_pc,
    output logic                 queue_full,
    output logic [31:0]          inst_to_dec,
    output logic [31:0]          pc_to_dec,
    output logic                 if_ls,
    input  logic                 if_station_idle,
    output logic [ADDR_BITS:0]   count,
    output logic [31:0]          issued_cnt
);

    localparam logic [ADDR_BITS:0] FULL_CNT   = (ADDR_BITS+1)'(DEPTH);
    localparam logic [6:0]         OPC_LOAD   = 7'b0000011;
    localparam logic [6:0]         OPC_STORE  = 7'b0100011;

    // Entry storage is deliberately not reset; validity is tracked by count.
    logic [31:0] inst_mem [DEPTH];
    logic [31:0] pc_mem   [DEPTH];

    logic [ADDR_BITS-1:0] head_q, head_d;
    logic [ADDR_BITS-1:0] tail_q, tail_d;
    logic [ADDR_BITS:0]   count_q, count_d;
    logic [31:0]          issued_q, issued_d;

    logic is_empty;
    logic is_full;
    logic push;
    logic pop;
    logic [31:0] head_inst;
    logic [31:0] head_pc;

    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == FULL_CNT);

    // Full is judged from the registered count only, so a pop in the same
    // cycle never frees a slot for the fetch offered alongside it.
    assign push = rdy_in & ~rob_clear & fetch_valid & ~is_full;
    assign pop  = rdy_in & ~rob_clear & ~is_empty & if_station_idle;

    // Next-state logic
    always_comb begin
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;
        issued_d = issued_q;

        if (rdy_in) begin
            if (rob_clear) begin
                // Flush drops everything; the issue counter keeps its history.
                head_d  = '0;
                tail_d  = '0;
                count_d = '0;
            end else begin
                if (push) begin
                    tail_d = tail_q + 1'b1;
                end
                if (pop) begin
                    head_d   = head_q + 1'b1;
                    issued_d = issued_q + 32'd1;
                end
                case ({push, pop})
                    2'b10:   count_d = count_q + 1'b1;
                    2'b01:   count_d = count_q - 1'b1;
                    default: count_d = count_q;
                endcase
            end
        end
    end

    // Control state
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            issued_q <= '0;
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            issued_q <= issued_d;
        end
    end

    // Entry storage write port
    always_ff @(posedge clk_in) begin
        if (push) begin
            inst_mem[tail_q] <= fetch_inst;
            pc_mem[tail_q]   <= fetch_pc;
        end
    end

    assign head_inst = inst_mem[head_q];
    assign head_pc   = pc_mem[head_q];

    // Decoder-facing outputs come straight from the head slot, no bypass of
    // the entry being written this cycle.
    always_comb begin
        inst_to_dec = 32'b0;
        pc_to_dec   = `emptyInst;
        if_ls       = 1'b0;
        if (!is_empty) begin
            inst_to_dec = head_inst;
            pc_to_dec   = head_pc;
            if_ls       = (head_inst[6:0] == OPC_LOAD) ||
                          (head_inst[6:0] == OPC_STORE);
        end
    end

    assign queue_full = is_full;
    assign count      = count_q;
    assign issued_cnt = issued_q;

endmodule

// File: tb/tb_issue_queue_ctrl.sv
// tb/tb_issue_queue_ctrl.sv - directed-vector bench for issue_queue_ctrl

`ifndef emptyInst
`define emptyInst 32'hFFFF_FFFF
`endif

module tb_issue_queue_ctrl;

    logic        clk_in;
    logic        rst_in;
    logic        rdy_in;
    logic        rob_clear;
    logic        fetch_valid;
    logic [31:0] fetch_inst;
    logic [31:0] fetch_pc;
    logic        queue_full;
    logic [31:0] inst_to_dec;
    logic [31:0] pc_to_dec;
    logic        if_ls;
    logic        if_station_idle;
    logic [4:0]  count;
    logic [31:0] issued_cnt;

    int n_vec  = 0;
    int n_miss = 0;

    issue_queue_ctrl #(.DEPTH(16), .ADDR_BITS(4)) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .rdy_in          (rdy_in),
        .rob_clear       (rob_clear),
        .fetch_valid     (fetch_valid),
        .fetch_inst      (fetch_inst),
        .fetch_pc        (fetch_pc),
        .queue_full      (queue_full),
        .inst_to_dec     (inst_to_dec),
        .pc_to_dec       (pc_to_dec),
        .if_ls           (if_ls),
        .if_station_idle (if_station_idle),
        .count           (count),
        .issued_cnt      (issued_cnt)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic push_one(input logic [31:0] inst, input logic [31:0] pc);
        fetch_valid = 1'b1;
        fetch_inst  = inst;
        fetch_pc    = pc;
        step();
        fetch_valid = 1'b0;
    endtask

    initial begin
        rst_in          = 1'b0;
        rdy_in          = 1'b1;
        rob_clear       = 1'b0;
        fetch_valid     = 1'b0;
        fetch_inst      = 32'h0;
        fetch_pc        = 32'h0;
        if_station_idle = 1'b0;

        // 1: reset state
        #2;
        check_val("rst_pc",     pc_to_dec,   `emptyInst);
        check_val("rst_inst",   inst_to_dec, 32'h0);
        check_val("rst_count",  count,       5'd0);
        check_val("rst_full",   queue_full,  1'b0);
        check_val("rst_ls",     if_ls,       1'b0);
        check_val("rst_issued", issued_cnt,  32'd0);
        step();
        rst_in = 1'b1;
        step();
        check_val("idle_count", count, 5'd0);

        // 2: single push, then pop
        push_one(32'h00500093, 32'h0);
        check_val("t2_inst",  inst_to_dec, 32'h00500093);
        check_val("t2_pc",    pc_to_dec,   32'h0);
        check_val("t2_ls",    if_ls,       1'b0);
        check_val("t2_count", count,       5'd1);
        if_station_idle = 1'b1;
        step();
        if_station_idle = 1'b0;
        check_val("t2_count_after", count,      5'd0);
        check_val("t2_issued",      issued_cnt, 32'd1);
        check_val("t2_pc_empty",    pc_to_dec,  `emptyInst);

        // 3: fill to full, ignored fetch, pop+fetch at full
        for (int i = 0; i < 16; i++) begin
            push_one(32'h00000013 + (i << 20), 32'h100 + 4 * i);
        end
        check_val("t3_count16", count,      5'd16);
        check_val("t3_full",    queue_full, 1'b1);
        check_val("t3_head",    pc_to_dec,  32'h100);
        push_one(32'h00000013, 32'h200);
        check_val("t3_ignored", count, 5'd16);
        fetch_valid     = 1'b1;
        fetch_inst      = 32'h00000013;
        fetch_pc        = 32'h200;
        if_station_idle = 1'b1;
        step();
        check_val("t3_pop_full_cnt",  count,      5'd15);
        check_val("t3_pop_full_flag", queue_full, 1'b0);
        check_val("t3_pop_full_head", pc_to_dec,  32'h104);
        if_station_idle = 1'b0;
        step();
        fetch_valid = 1'b0;
        check_val("t3_retry_taken", count, 5'd16);
        if_station_idle = 1'b1;
        for (int k = 1; k < 16; k++) begin
            check_val($sformatf("t3_order_%0d", k), pc_to_dec, 32'h100 + 4 * k);
            step();
        end
        check_val("t3_order_last", pc_to_dec, 32'h200);
        step();
        if_station_idle = 1'b0;
        check_val("t3_drained", count,      5'd0);
        check_val("t3_issued",  issued_cnt, 32'd18);

        // 4: load/store classification in order
        push_one(32'h0002a303, 32'h400);
        push_one(32'h0062a023, 32'h404);
        push_one(32'h00628333, 32'h408);
        check_val("t4_lw_ls", if_ls,     1'b1);
        check_val("t4_lw_pc", pc_to_dec, 32'h400);
        if_station_idle = 1'b1;
        step();
        check_val("t4_sw_ls", if_ls,     1'b1);
        check_val("t4_sw_pc", pc_to_dec, 32'h404);
        step();
        check_val("t4_add_ls",   if_ls,       1'b0);
        check_val("t4_add_pc",   pc_to_dec,   32'h408);
        check_val("t4_add_inst", inst_to_dec, 32'h00628333);
        step();
        if_station_idle = 1'b0;
        check_val("t4_empty_ls", if_ls,      1'b0);
        check_val("t4_issued",   issued_cnt, 32'd21);

        // 5: flush with fetch and pop requested, then wrap traffic
        for (int i = 0; i < 5; i++) begin
            push_one(32'h0002a303, 32'h500 + 4 * i);
        end
        check_val("t5_count5", count, 5'd5);
        rob_clear       = 1'b1;
        fetch_valid     = 1'b1;
        fetch_pc        = 32'h5FC;
        if_station_idle = 1'b1;
        step();
        rob_clear       = 1'b0;
        fetch_valid     = 1'b0;
        if_station_idle = 1'b0;
        check_val("t5_flush_cnt",    count,      5'd0);
        check_val("t5_flush_pc",     pc_to_dec,  `emptyInst);
        check_val("t5_flush_issued", issued_cnt, 32'd21);
        check_val("t5_flush_ls",     if_ls,      1'b0);
        push_one(32'h00000013, 32'h1000);
        if_station_idle = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            check_val($sformatf("t5_wrap_%0d", i), pc_to_dec, 32'h1000 + 4 * (i - 1));
            fetch_valid = 1'b1;
            fetch_inst  = 32'h00000013;
            fetch_pc    = 32'h1000 + 4 * i;
            step();
        end
        fetch_valid = 1'b0;
        check_val("t5_wrap_cnt",    count,      5'd1);
        check_val("t5_wrap_head",   pc_to_dec,  32'h1050);
        check_val("t5_wrap_issued", issued_cnt, 32'd41);
        step();
        if_station_idle = 1'b0;
        check_val("t5_drain_cnt", count,      5'd0);
        check_val("t5_issued",    issued_cnt, 32'd42);

        // 6: rdy_in low freezes everything, then async reset mid-cycle
        push_one(32'h00000013, 32'h600);
        push_one(32'h00000013, 32'h604);
        push_one(32'h00000013, 32'h608);
        rdy_in          = 1'b0;
        fetch_valid     = 1'b1;
        fetch_pc        = 32'h6FC;
        if_station_idle = 1'b1;
        rob_clear       = 1'b1;
        step();
        step();
        step();
        check_val("t6_frz_cnt",    count,      5'd3);
        check_val("t6_frz_pc",     pc_to_dec,  32'h600);
        check_val("t6_frz_issued", issued_cnt, 32'd42);
        rdy_in          = 1'b1;
        rob_clear       = 1'b0;
        fetch_valid     = 1'b0;
        if_station_idle = 1'b0;
        step();
        check_val("t6_unfrz_cnt", count, 5'd3);
        rst_in = 1'b0;
        #1;
        check_val("t6_arst_cnt",    count,       5'd0);
        check_val("t6_arst_pc",     pc_to_dec,   `emptyInst);
        check_val("t6_arst_inst",   inst_to_dec, 32'h0);
        check_val("t6_arst_full",   queue_full,  1'b0);
        check_val("t6_arst_issued", issued_cnt,  32'd0);
        step();
        rst_in = 1'b1;
        step();
        check_val("t6_post_cnt", count, 5'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
